// File: rtl/voice_mixer.sv
// Sequential voice mixer: snapshot on sample_tick, accumulate one enabled voice per cycle,
// scale by master volume, saturate to WIDTH and hold the result for the DAC transmitter.
module voice_mixer #(
  parameter int N_VOICES   = 16,
  parameter int WIDTH      = 24,
  parameter int GAIN_SHIFT = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_tick,
  input  logic [N_VOICES-1:0][WIDTH-1:0]   voices,
  input  logic [N_VOICES-1:0]              voice_en,
  input  logic [7:0]                       volume,
  output logic signed [WIDTH-1:0]          sample_out,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             clip,
  output logic                             overrun
);

  localparam int IDX_W  = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int ACC_W  = WIDTH + $clog2(N_VOICES) + 1;
  localparam int PROD_W = ACC_W + 9;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

  state_t                            state, state_next;
  logic [N_VOICES-1:0][WIDTH-1:0]    snap_voices;
  logic [N_VOICES-1:0]               snap_en;
  logic signed [ACC_W-1:0]           acc;
  logic [IDX_W-1:0]                  idx;
  logic signed [PROD_W-1:0]          scaled;
  logic signed [ACC_W-1:0]           addend;
  logic signed [PROD_W-1:0]          product;
  logic                              sat_hi, sat_lo;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable assigned in this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_tick) state_next = ACCUM;
      ACCUM:   if (idx == LAST_IDX) state_next = SCALE;
      SCALE:   state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addend  = '0;
    if (snap_en[idx]) addend = ACC_W'($signed(snap_voices[idx]));
    // The zero-extended volume keeps the multiply signed without treating gain >= 128 as negative.
    product = PROD_W'(acc) * PROD_W'($signed({1'b0, volume}));
    sat_hi  = (scaled > SAT_MAX);
    sat_lo  = (scaled < SAT_MIN);
  end

  // NOTE: the snapshot is a data-only register; it is always rewritten before use, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && sample_tick) begin
      snap_voices <= voices;
      snap_en     <= voice_en;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      idx        <= '0;
      scaled     <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      clip       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      clip      <= 1'b0;
      if (sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            acc <= '0;
            idx <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + addend;
          idx <= idx + IDX_W'(1);
        end
        SCALE: scaled <= product >>> GAIN_SHIFT;
        OUT: begin
          if (sat_hi)      sample_out <= SAT_MAX[WIDTH-1:0];
          else if (sat_lo) sample_out <= SAT_MIN[WIDTH-1:0];
          else             sample_out <= scaled[WIDTH-1:0];
          clip      <= sat_hi | sat_lo;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
